sextium_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single port-A memory interface of the Sextium RAM controller. Requester 0 is the CPU and requester 1 is the DMA/IO master. Each transaction is granted, registered and issued as a single mem_read or mem_write request. The arbiter waits for mem_ack, captures the read data and returns a one-cycle acknowledge to the owning requester. It sits between the CPU/DMA buses and the RAM controller, and it owns all port-A traffic.

---
 rtl/sextium_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_sextium_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sextium_mem_arbiter.sv
// Two-requester arbiter sharing the Sextium RAM port A (CPU = 0, DMA/IO = 1).
// Define SEXTIUM_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority.
module sextium_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_read,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_ack,
    input  logic              req1_read,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_ack,
    output logic [ADDR_W-1:0] addr_bus,
    output logic [DATA_W-1:0] mem_bus_out,
    input  logic [DATA_W-1:0] mem_bus_in,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_ack,
    output logic              grant,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    logic   op_write;
    logic   pend0;
    logic   pend1;
    logic   win;
    logic   win_write;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    assign pend0 = req0_read | req0_write;
    assign pend1 = req1_read | req1_write;

`ifdef SEXTIUM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    always_comb begin
        win = ~pend0;
        if (pend0 && pend1)
            win = ~last_grant;
    end
`else
    always_comb begin
        win = ~pend0;
    end
`endif

    // Write wins when a requester raises read and write together.
    always_comb begin
        win_write = win ? req1_write : req0_write;
        win_addr  = win ? req1_addr  : req0_addr;
        win_wdata = win ? req1_wdata : req0_wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op_write    <= 1'b0;
            grant       <= 1'b0;
            busy        <= 1'b0;
            addr_bus    <= '0;
            mem_bus_out <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            req0_ack    <= 1'b0;
            req1_ack    <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
`ifdef SEXTIUM_ARB_ROUND_ROBIN_EN
            last_grant  <= 1'b1;
`endif
        end else begin
            req0_ack <= 1'b0;
            req1_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pend0 || pend1) begin
                        state       <= ACCESS;
                        busy        <= 1'b1;
                        grant       <= win;
                        addr_bus    <= win_addr;
                        mem_bus_out <= win_wdata;
                        op_write    <= win_write;
                        mem_read    <= ~win_write;
                        mem_write   <= win_write;
`ifdef SEXTIUM_ARB_ROUND_ROBIN_EN
                        last_grant  <= win;
`endif
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        if (!op_write) begin
                            if (grant)
                                req1_rdata <= mem_bus_in;
                            else
                                req0_rdata <= mem_bus_in;
                        end
                        // Strobes drop here so the controller never re-acks.
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        req0_ack  <= ~grant;
                        req1_ack  <= grant;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sextium_mem_arbiter.sv
// Directed bench for sextium_mem_arbiter with a small RAM-controller model.
// Covers reset, single ops, contention, collision, late ack and mid-op reset.
module tb_sextium_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0_read = 1'b0, req0_write = 1'b0;
    logic [15:0] req0_addr = '0, req0_wdata = '0;
    logic [15:0] req0_rdata;
    logic        req0_ack;
    logic        req1_read = 1'b0, req1_write = 1'b0;
    logic [15:0] req1_addr = '0, req1_wdata = '0;
    logic [15:0] req1_rdata;
    logic        req1_ack;
    logic [15:0] addr_bus, mem_bus_out;
    logic [15:0] mem_bus_in;
    logic        mem_read, mem_write, mem_ack;
    logic        grant, busy;

    int checks = 0;
    int failures = 0;
    int ack_delay = 0;

    logic [15:0] mem [0:255];
    logic [3:0]  ack_cnt;

    sextium_mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clock(clock), .reset(reset),
        .req0_read(req0_read), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_rdata(req0_rdata), .req0_ack(req0_ack),
        .req1_read(req1_read), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_rdata(req1_rdata), .req1_ack(req1_ack),
        .addr_bus(addr_bus), .mem_bus_out(mem_bus_out),
        .mem_bus_in(mem_bus_in), .mem_read(mem_read),
        .mem_write(mem_write), .mem_ack(mem_ack),
        .grant(grant), .busy(busy)
    );

    always #5 clock = ~clock;

    // RAM controller: acks after ack_delay extra cycles, never twice in a row.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_ack     <= 1'b0;
            ack_cnt     <= '0;
            mem_bus_in  <= '0;
            mem[8'h10]  <= 16'hBEEF;
            mem[8'h30]  <= 16'hCAFE;
            mem[8'hFF]  <= 16'h0F0F;
        end else if ((mem_read || mem_write) && !mem_ack) begin
            if (ack_cnt == ack_delay[3:0]) begin
                mem_ack    <= 1'b1;
                ack_cnt    <= '0;
                mem_bus_in <= mem[addr_bus[7:0]];
                if (mem_write)
                    mem[addr_bus[7:0]] <= mem_bus_out;
            end else begin
                ack_cnt <= ack_cnt + 4'd1;
            end
        end else begin
            mem_ack <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r0, w0;
        logic [15:0] a0, d0;
        logic        r1, w1;
        logic [15:0] a1, d1;
        int          dly;
        int          lat;
        logic        g;
        logic [15:0] rd0, rd1;
        int          rc, wc;
    } vec_t;

    vec_t v[8];

    task automatic run_vec(input vec_t t);
        int n = 0;
        int rc = 0;
        int wc = 0;
        logic got = 1'b0;
        req0_read = t.r0; req0_write = t.w0;
        req0_addr = t.a0; req0_wdata = t.d0;
        req1_read = t.r1; req1_write = t.w1;
        req1_addr = t.a1; req1_wdata = t.d1;
        ack_delay = t.dly;
        while (!got && n < 20) begin
            @(posedge clock); #1;
            n++;
            if (req0_ack || req1_ack)
                got = 1'b1;
            else begin
                rc += int'(mem_read);
                wc += int'(mem_write);
            end
        end
        chk("ack_seen", {31'd0, got}, 32'd1);
        chk("latency", n, t.lat);
        chk("ack_owner", {30'd0, req1_ack, req0_ack}, t.g ? 32'd2 : 32'd1);
        chk("grant", {31'd0, grant}, {31'd0, t.g});
        chk("addr_bus", {16'd0, addr_bus}, {16'd0, t.g ? t.a1 : t.a0});
        chk("rdata0", {16'd0, req0_rdata}, {16'd0, t.rd0});
        chk("rdata1", {16'd0, req1_rdata}, {16'd0, t.rd1});
        chk("read_cycles", rc, t.rc);
        chk("write_cycles", wc, t.wc);
        req0_read = 1'b0; req0_write = 1'b0;
        req1_read = 1'b0; req1_write = 1'b0;
        @(posedge clock); #1;
        chk("idle_after", {30'd0, busy, req0_ack | req1_ack}, 32'd0);
        ack_delay = 0;
        @(negedge clock);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {busy, grant, req0_ack, req1_ack, mem_read, mem_write},
            32'd0);
        chk({name, "_rdata"}, {req1_rdata, req0_rdata}, 32'd0);
        chk({name, "_bus"}, {addr_bus, mem_bus_out}, 32'd0);
    endtask

    initial begin
        v[0] = '{1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000,
                 0,3,0,16'hBEEF,16'h0000,2,0};
        v[1] = '{0,0,16'h0000,16'h0000, 0,1,16'h00FF,16'h1234,
                 0,3,1,16'hBEEF,16'h0000,0,2};
        v[2] = '{0,0,16'h0000,16'h0000, 1,0,16'h00FF,16'h0000,
                 0,3,1,16'hBEEF,16'h1234,2,0};
        v[3] = '{1,1,16'h0020,16'h5555, 0,0,16'h0000,16'h0000,
                 0,3,0,16'hBEEF,16'h1234,0,2};
        v[4] = '{0,0,16'h0000,16'h0000, 1,0,16'h0020,16'h0000,
                 0,3,1,16'hBEEF,16'h5555,2,0};
        v[5] = '{1,0,16'h0030,16'h0000, 0,0,16'h0000,16'h0000,
                 2,5,0,16'hCAFE,16'h5555,4,0};
        v[6] = '{0,1,16'h0010,16'h00A5, 0,0,16'h0000,16'h0000,
                 0,3,0,16'hCAFE,16'h5555,0,2};
        v[7] = '{1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000,
                 0,3,0,16'h00A5,16'h5555,2,0};

        #12;
        chk_reset_outputs("reset_state");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Contention: both read continuously; acked requester re-asserts.
        begin
            int n;
            logic got;
            logic g;
            logic expg;
            req0_read = 1'b1; req0_addr = 16'h0010;
            req1_read = 1'b1; req1_addr = 16'h00FF;
            for (int k = 0; k < 4; k++) begin
                n = 0;
                got = 1'b0;
                while (!got && n < 20) begin
                    @(posedge clock); #1;
                    n++;
                    got = req0_ack | req1_ack;
                end
`ifdef SEXTIUM_ARB_ROUND_ROBIN_EN
                expg = k[0];
`else
                expg = 1'b0;
`endif
                g = grant;
                chk("cont_ack_seen", {31'd0, got}, 32'd1);
                chk("cont_grant", {31'd0, g}, {31'd0, expg});
                chk("cont_interval", n, (k == 0) ? 32'd3 : 32'd4);
                if (g) req1_read = 1'b0;
                else   req0_read = 1'b0;
                @(negedge clock);
                if (g) req1_read = 1'b1;
                else   req0_read = 1'b1;
            end
`ifdef SEXTIUM_ARB_ROUND_ROBIN_EN
            chk("cont_rdata1", {16'd0, req1_rdata}, 32'h0F0F);
`else
            chk("cont_rdata1", {16'd0, req1_rdata}, 32'h0000);
`endif
            chk("cont_rdata0", {16'd0, req0_rdata}, 32'hBEEF);
            req0_read = 1'b0;
            req1_read = 1'b0;
        end

        reset = 1'b0;
        #1;
        chk_reset_outputs("reset_after_cont");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            run_vec(v[i]);
            if (i == 3)
                chk("collision_mem", {16'd0, mem[8'h20]}, 32'h5555);
        end

        // Reset while the arbiter is in ACCESS.
        req1_read = 1'b1; req1_addr = 16'h0030;
        ack_delay = 3;
        @(posedge clock); #1;
        chk("pre_reset_access", {30'd0, busy, mem_read}, 32'd3);
        reset = 1'b0;
        #1;
        chk_reset_outputs("midop_reset");
        req1_read = 1'b0;
        ack_delay = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            chk("no_ack_in_reset", {30'd0, req1_ack, req0_ack}, 32'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_vec('{0,0,16'h0000,16'h0000, 1,0,16'h0030,16'h0000,
                  0,3,1,16'h0000,16'hCAFE,2,0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
